// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction-fetch stage of the pipelined MIPS core.
//
// Owns the fetch PC, a word-addressed instruction memory (written by an
// external loader) and the IF/ID pipeline register. The hazard/branch logic
// downstream can stall, flush or redirect this stage.
//
// Ports
//   clk_i            in   clock, all state updates on posedge
//   rst_i            in   asynchronous active-low reset
//   stall_i          in   hold PC and IF/ID this cycle
//   flush_i          in   squash IF/ID (load a bubble) this cycle
//   branch_taken_i   in   redirect fetch to branch_target_i
//   branch_target_i  in   byte address of redirect target
//   imem_wr_en_i     in   loader write strobe
//   imem_wr_addr_i   in   loader word index
//   imem_wr_data_i   in   loader write data
//   pc_o             out  current fetch PC (byte address)
//   ifid_instr_o     out  IF/ID instruction word
//   ifid_pc4_o       out  IF/ID PC+4 of that instruction
//   ifid_valid_o     out  IF/ID holds a real instruction (0 = bubble)
//   halt_o           out  sticky: fetch attempted at an invalid PC
// ============================================================================
module if_stage #(
    parameter int          INSTR_NUM = 256,
    parameter logic [31:0] RESET_PC  = 32'h0,
    localparam int         AW        = $clog2(INSTR_NUM)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          branch_taken_i,
    input  logic [31:0]   branch_target_i,
    input  logic          imem_wr_en_i,
    input  logic [AW-1:0] imem_wr_addr_i,
    input  logic [31:0]   imem_wr_data_i,
    output logic [31:0]   pc_o,
    output logic [31:0]   ifid_instr_o,
    output logic [31:0]   ifid_pc4_o,
    output logic          ifid_valid_o,
    output logic          halt_o
);

    logic [31:0] r_mem [INSTR_NUM];

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_halt;

    logic        w_pc_valid;
    logic        w_wr_ok;
    logic [31:0] w_pc4;
    logic [31:0] w_fetch;

    // A PC is fetchable only when word aligned and inside the memory.
    assign w_pc_valid = (r_pc[1:0] == 2'b00) &&
                        ({2'b00, r_pc[31:2]} < 32'(INSTR_NUM));
    assign w_wr_ok    = ({1'b0, imem_wr_addr_i} < (AW+1)'(INSTR_NUM));
    assign w_pc4      = r_pc + 32'd4;
    // Combinational read of the array; a write on the same edge lands via
    // NBA, so the fetch on that edge sees the old word.
    assign w_fetch    = r_mem[r_pc[AW+1:2]];

    // Loader port; memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (imem_wr_en_i && w_wr_ok)
            r_mem[imem_wr_addr_i] <= imem_wr_data_i;
    end

    // PC and halt flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc   <= RESET_PC;
            r_halt <= 1'b0;
        end else begin
            if (branch_taken_i) begin
                // Redirect wins over everything and clears halt; the new
                // target is validated on the following edge.
                r_pc   <= branch_target_i;
                r_halt <= 1'b0;
            end else begin
                if (!stall_i && !r_halt && w_pc_valid)
                    r_pc <= w_pc4;
                if (!stall_i && !w_pc_valid)
                    r_halt <= 1'b1;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_instr <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (branch_taken_i || flush_i) begin
            r_instr <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (stall_i) begin
            r_instr <= r_instr;
            r_pc4   <= r_pc4;
            r_valid <= r_valid;
        end else if (r_halt || !w_pc_valid) begin
            r_instr <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            r_instr <= w_fetch;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
        end
    end

    assign pc_o         = r_pc;
    assign ifid_instr_o = r_instr;
    assign ifid_pc4_o   = r_pc4;
    assign ifid_valid_o = r_valid;
    assign halt_o       = r_halt;

endmodule
